// File: rtl/trace_capture_buffer.sv
// trace_capture_buffer: trigger-driven sample capture into a double-buffered
// trace RAM. One screen-wide trace of y-coordinates is captured per trigger.
// The display bank answers pixel hit queries with one cycle of latency.
module trace_capture_buffer #(
    parameter int MAX_X        = 640,
    parameter int Y_OFFSET     = 112,
    parameter int DECIM        = 1,
    parameter int AUTO_TIMEOUT = 2048
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] sample,
    input  logic       sample_valid,
    output logic       sample_ready,
    input  logic [7:0] trig_level,
    input  logic       frame_start,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic       trace_hit,
    output logic       capture_busy
);

    localparam int AW = (MAX_X > 1) ? $clog2(MAX_X) : 1;
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int TW = (AUTO_TIMEOUT > 2) ? $clog2(AUTO_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_ARM     = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] decim_q, decim_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic [7:0]    prev_q, prev_d;
    logic          prev_ok_q, prev_ok_d;
    logic          bank_sel_q, bank_sel_d;     // bank currently being written
    logic          disp_valid_q, disp_valid_d;
    logic          trace_hit_q, trace_hit_d;

    logic          xfer;
    logic          dec;
    logic          trig_edge;
    logic          trig_auto;
    logic [9:0]    y_new;
    logic          we;
    logic [AW-1:0] wr_idx;
    logic          in_range;
    logic [AW-1:0] rd_addr;
    logic [9:0]    disp_word;

    logic [9:0]    bank0 [MAX_X];
    logic [9:0]    bank1 [MAX_X];

    assign sample_ready = (state_q != ST_FULL);
    assign capture_busy = (state_q != ST_ARM);
    assign trace_hit    = trace_hit_q;

    // Next-state logic: decimation, trigger detection, capture sequencing, bank swap.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        decim_d      = decim_q;
        timeout_d    = timeout_q;
        prev_d       = prev_q;
        prev_ok_d    = prev_ok_q;
        bank_sel_d   = bank_sel_q;
        disp_valid_d = disp_valid_q;
        we           = 1'b0;
        wr_idx       = wr_addr_q;

        xfer      = sample_valid && sample_ready;
        dec       = xfer && (decim_q == '0);
        y_new     = 10'(Y_OFFSET) + {2'b00, ~sample};   // 255 - s == ~s for 8 bits
        trig_edge = prev_ok_q && (prev_q < trig_level) && (sample >= trig_level);
        trig_auto = (AUTO_TIMEOUT != 0) && (timeout_q == TW'(AUTO_TIMEOUT - 1));

        // Decimation phase runs across state changes; it is never realigned.
        if (xfer) begin
            decim_d = (decim_q == DW'(DECIM - 1)) ? '0 : decim_q + DW'(1);
        end

        case (state_q)
            ST_ARM: begin
                if (dec) begin
                    prev_d    = sample;
                    prev_ok_d = 1'b1;
                    if (trig_edge || trig_auto) begin
                        we        = 1'b1;
                        wr_idx    = '0;
                        wr_addr_d = AW'(1);
                        state_d   = ST_CAPTURE;
                    end else begin
                        timeout_d = timeout_q + TW'(1);
                    end
                end
            end
            ST_CAPTURE: begin
                if (dec) begin
                    we     = 1'b1;
                    wr_idx = wr_addr_q;
                    if (wr_addr_q == AW'(MAX_X - 1)) begin
                        state_d = ST_FULL;
                    end else begin
                        wr_addr_d = wr_addr_q + AW'(1);
                    end
                end
            end
            ST_FULL: begin
                if (frame_start) begin
                    bank_sel_d   = ~bank_sel_q;
                    disp_valid_d = 1'b1;
                    prev_ok_d    = 1'b0;
                    timeout_d    = '0;
                    state_d      = ST_ARM;
                end
            end
            default: state_d = ST_ARM;
        endcase
    end

    // Pixel hit lookup against the display bank (the one not being written).
    always_comb begin
        in_range    = (32'(pix_x) < MAX_X);
        rd_addr     = in_range ? AW'(pix_x) : '0;
        disp_word   = bank_sel_q ? bank0[rd_addr] : bank1[rd_addr];
        trace_hit_d = disp_valid_q && in_range && (disp_word == pix_y);
    end

    // Control registers with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_ARM;
            wr_addr_q    <= '0;
            decim_q      <= '0;
            timeout_q    <= '0;
            prev_q       <= '0;
            prev_ok_q    <= 1'b0;
            bank_sel_q   <= 1'b0;
            disp_valid_q <= 1'b0;
            trace_hit_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            decim_q      <= decim_d;
            timeout_q    <= timeout_d;
            prev_q       <= prev_d;
            prev_ok_q    <= prev_ok_d;
            bank_sel_q   <= bank_sel_d;
            disp_valid_q <= disp_valid_d;
            trace_hit_q  <= trace_hit_d;
        end
    end

    // Trace RAM write port into the capture bank.
    // NOTE: the RAM is deliberately not reset; disp_valid masks stale contents, which keeps it mappable to block RAM.
    always_ff @(posedge clk) begin
        if (we && reset_n) begin
            if (bank_sel_q) begin
                bank1[wr_idx] <= y_new;
            end else begin
                bank0[wr_idx] <= y_new;
            end
        end
    end

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Scoreboard bench for trace_capture_buffer: stimulus pushes expected output
// bits into a queue; a monitor pops and compares them one clock later.
module tb_trace_capture_buffer;

    logic       clk = 1'b0;
    logic       reset_n;

    // Default-parameter instance.
    logic [7:0] sample, trig_level;
    logic       sample_valid, sample_ready, frame_start, trace_hit, capture_busy;
    logic [9:0] pix_x, pix_y;

    // DECIM = 4, AUTO_TIMEOUT = 16 instance.
    logic [7:0] a_sample, a_trig;
    logic       a_valid, a_ready, a_frame_start, a_hit, a_busy;
    logic [9:0] a_pix_x, a_pix_y;

    trace_capture_buffer dut (
        .clk(clk), .reset_n(reset_n),
        .sample(sample), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .trig_level(trig_level), .frame_start(frame_start),
        .pix_x(pix_x), .pix_y(pix_y),
        .trace_hit(trace_hit), .capture_busy(capture_busy)
    );

    trace_capture_buffer #(.MAX_X(640), .Y_OFFSET(112), .DECIM(4), .AUTO_TIMEOUT(16)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .sample(a_sample), .sample_valid(a_valid), .sample_ready(a_ready),
        .trig_level(a_trig), .frame_start(a_frame_start),
        .pix_x(a_pix_x), .pix_y(a_pix_y),
        .trace_hit(a_hit), .capture_busy(a_busy)
    );

    typedef struct {
        string name;
        int    sig;   // 0 hit, 1 ready, 2 busy, 3 a_hit, 4 a_ready, 5 a_busy
        logic  exp;
    } exp_t;

    exp_t exp_q[$];
    logic chk_req   = 1'b0;
    logic chk_stage = 1'b0;
    int   n_vec     = 0;
    int   n_err     = 0;

    always #5 clk = ~clk;

    // Expectations pushed during a cycle are checked after the following posedge.
    always @(posedge clk) chk_stage <= chk_req;

    function automatic logic pick(input int sig);
        case (sig)
            0: return trace_hit;
            1: return sample_ready;
            2: return capture_busy;
            3: return a_hit;
            4: return a_ready;
            5: return a_busy;
            default: return 1'bx;
        endcase
    endfunction

    // Monitor: compare every queued expectation at the falling edge.
    always @(negedge clk) begin
        exp_t it;
        if (chk_stage) begin
            while (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                n_vec++;
                if (pick(it.sig) !== it.exp) begin
                    n_err++;
                    $display("FAIL %s: got %b, expected %b", it.name, pick(it.sig), it.exp);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_bit(input string nm, input int sig, input logic e);
        exp_t it;
        it.name = nm;
        it.sig  = sig;
        it.exp  = e;
        exp_q.push_back(it);
    endtask

    task automatic fire();
        chk_req = 1'b1;
        step();
        chk_req = 1'b0;
    endtask

    task automatic probe(input bit on_a, input int x, input int y, input logic e, input string tag);
        if (on_a) begin
            a_pix_x = 10'(x);
            a_pix_y = 10'(y);
            expect_bit($sformatf("%s a_hit(%0d,%0d)", tag, x, y), 3, e);
        end else begin
            pix_x = 10'(x);
            pix_y = 10'(y);
            expect_bit($sformatf("%s hit(%0d,%0d)", tag, x, y), 0, e);
        end
        fire();
    endtask

    initial begin
        reset_n = 1'b0;
        sample = '0; sample_valid = 1'b0; trig_level = 8'd128; frame_start = 1'b0;
        pix_x = '0; pix_y = '0;
        a_sample = '0; a_valid = 1'b0; a_trig = 8'h80; a_frame_start = 1'b0;
        a_pix_x = '0; a_pix_y = '0;
        step();
        step();

        // Reset state.
        expect_bit("reset hit", 0, 1'b0);
        expect_bit("reset ready", 1, 1'b1);
        expect_bit("reset busy", 2, 1'b0);
        expect_bit("reset a_busy", 5, 1'b0);
        fire();
        reset_n = 1'b1;
        step();

        // Ramp 0..255 repeating, trigger at 128; last write coincides with frame_start.
        for (int i = 0; i < 768; i++) begin
            sample = 8'(i);
            sample_valid = 1'b1;
            if (i == 127) expect_bit("ramp pre-trigger busy", 2, 1'b0);
            if (i == 128) expect_bit("ramp trigger busy", 2, 1'b1);
            if (i == 766) expect_bit("ramp last-but-one ready", 1, 1'b1);
            if (i == 767) begin
                frame_start = 1'b1;
                expect_bit("ramp full ready", 1, 1'b0);
                expect_bit("ramp full busy", 2, 1'b1);
            end
            if (exp_q.size() > 0) fire(); else step();
            frame_start = 1'b0;
        end

        // Held in FULL with different samples: no writes, no swap yet.
        for (int j = 0; j < 20; j++) begin
            sample = 8'd0;
            step();
        end
        probe(1'b0, 0, 239, 1'b0, "coincident no swap");
        expect_bit("full hold ready", 1, 1'b0);
        fire();

        // Swap: reads in the frame_start cycle still see the old (masked) bank.
        frame_start = 1'b1;
        pix_x = 10'd0; pix_y = 10'd239;
        expect_bit("swap-cycle hit", 0, 1'b0);
        expect_bit("ready after swap", 1, 1'b1);
        fire();
        frame_start = 1'b0;
        sample_valid = 1'b0;

        probe(1'b0, 0, 239, 1'b1, "ramp");
        probe(1'b0, 1, 238, 1'b1, "ramp");
        probe(1'b0, 0, 240, 1'b0, "ramp");
        probe(1'b0, 100, 139, 1'b1, "ramp");
        probe(1'b0, 127, 112, 1'b1, "ramp");
        probe(1'b0, 128, 367, 1'b1, "ramp");
        probe(1'b0, 639, 112, 1'b1, "ramp");
        probe(1'b0, 639, 113, 1'b0, "ramp");
        probe(1'b0, 640, 239, 1'b0, "x range");
        probe(1'b0, 700, 239, 1'b0, "x range");
        probe(1'b0, 1023, 239, 1'b0, "x range");

        // Second capture, interrupted by reset while wr_addr = 300.
        trig_level = 8'd200;
        for (int i = 0; i < 500; i++) begin
            sample = 8'(i);
            sample_valid = 1'b1;
            if (i == 199) expect_bit("cap2 pre-trigger busy", 2, 1'b0);
            if (i == 200) expect_bit("cap2 trigger busy", 2, 1'b1);
            if (exp_q.size() > 0) fire(); else step();
        end
        sample_valid = 1'b0;
        reset_n = 1'b0;
        pix_x = 10'd0; pix_y = 10'd239;
        expect_bit("mid reset hit", 0, 1'b0);
        expect_bit("mid reset busy", 2, 1'b0);
        expect_bit("mid reset ready", 1, 1'b1);
        fire();
        reset_n = 1'b1;
        probe(1'b0, 0, 239, 1'b0, "masked after reset");
        probe(1'b0, 1, 238, 1'b0, "masked after reset");
        probe(1'b0, 639, 112, 1'b0, "masked after reset");

        // Third capture restarts at address 0.
        trig_level = 8'd50;
        for (int i = 0; i < 690; i++) begin
            sample = 8'(i);
            sample_valid = 1'b1;
            if (i == 49) expect_bit("cap3 pre-trigger busy", 2, 1'b0);
            if (i == 50) expect_bit("cap3 trigger busy", 2, 1'b1);
            if (i == 689) expect_bit("cap3 full ready", 1, 1'b0);
            if (exp_q.size() > 0) fire(); else step();
        end
        sample_valid = 1'b0;
        frame_start = 1'b1;
        expect_bit("cap3 swap ready", 1, 1'b1);
        fire();
        frame_start = 1'b0;
        probe(1'b0, 0, 317, 1'b1, "cap3");
        probe(1'b0, 1, 316, 1'b1, "cap3");
        probe(1'b0, 0, 239, 1'b0, "cap3");
        probe(1'b0, 300, 273, 1'b1, "cap3");
        probe(1'b0, 1023, 317, 1'b0, "cap3 x range");

        // DECIM = 4, constant 0x40, forced trigger on the 16th decimated sample.
        for (int t = 1; t <= 2630; t++) begin
            a_sample = 8'h40;
            a_valid = 1'b1;
            if (t == 60) expect_bit("auto pre-trigger busy", 5, 1'b0);
            if (t == 64) expect_bit("auto trigger busy", 5, 1'b1);
            if (t == 2616) expect_bit("auto last-but-one ready", 4, 1'b1);
            if (t == 2617) expect_bit("auto full ready", 4, 1'b0);
            if (exp_q.size() > 0) fire(); else step();
        end
        a_valid = 1'b0;
        a_frame_start = 1'b1;
        expect_bit("auto swap ready", 4, 1'b1);
        fire();
        a_frame_start = 1'b0;
        probe(1'b1, 0, 303, 1'b1, "auto");
        probe(1'b1, 320, 303, 1'b1, "auto");
        probe(1'b1, 639, 303, 1'b1, "auto");
        probe(1'b1, 320, 302, 1'b0, "auto");
        probe(1'b1, 640, 303, 1'b0, "auto x range");

        step();
        step();
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard drain: %0d left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
